// File: rtl/uart_rx.sv
// uart_rx -- oversampled 8N1 UART receiver.
//
// Deserialises an asynchronous serial line, LSB first, sampling each bit at
// its centre using an OVERSAMPLE x baud clock. Each correctly framed byte is
// presented on rx_dout with a one-cycle rx_done_tk tick. A low stop bit
// raises a one-cycle rx_frame_err and the receiver then waits for the line
// to return high before it hunts for a new start bit.
//
// Ports:
//   BCLK         in   baud-oversample clock (OVERSAMPLE x baud rate)
//   reset        in   asynchronous, active-high reset
//   rx           in   raw serial line, asynchronous to BCLK, idle high
//   rx_dout      out  last correctly framed byte (bit 0 = first data bit)
//   rx_done_tk   out  one-cycle pulse, rx_dout has just been updated
//   rx_frame_err out  one-cycle pulse, stop bit was sampled low
//   rx_busy      out  high whenever the receiver is not idle
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DATA_BITS  = $clog2(DATA_WIDTH)
) (
  input  logic                  BCLK,
  input  logic                  reset,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_dout,
  output logic                  rx_done_tk,
  output logic                  rx_frame_err,
  output logic                  rx_busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);

  // Half a bit after the falling edge lands in the middle of the start bit;
  // from there every full bit period lands in the middle of the next bit.
  localparam logic [TICK_W-1:0]    TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [DATA_BITS-1:0] BIT_LAST  = DATA_BITS'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t                state;
  logic [TICK_W-1:0]     tick;
  logic [DATA_BITS-1:0]  bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  rx_meta;
  logic                  rx_sync;

  // Synchroniser stage: both flops reset to the idle (high) line level so a
  // reset never looks like a start bit.
  always_ff @(posedge BCLK or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receive FSM stage: all outputs are registered here. The tick counter is
  // cleared on every state change so each state measures from its own entry.
  always_ff @(posedge BCLK or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tick         <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      rx_dout      <= '0;
      rx_done_tk   <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_done_tk   <= 1'b0;
      rx_frame_err <= 1'b0;

      case (state)
        IDLE: begin
          tick <= '0;
          if (!rx_sync) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (tick == TICK_MID) begin
            tick <= '0;
            if (!rx_sync) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              // Line is back high mid start bit: a glitch, not a frame.
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        DATA: begin
          if (tick == TICK_LAST) begin
            tick  <= '0;
            // LSB arrives first, so shifting right leaves it in bit 0.
            shift <= {rx_sync, shift[DATA_WIDTH-1:1]};
            if (bit_cnt == BIT_LAST) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        STOP: begin
          if (tick == TICK_LAST) begin
            tick <= '0;
            if (rx_sync) begin
              rx_dout    <= shift;
              rx_done_tk <= 1'b1;
              state      <= IDLE;
              rx_busy    <= 1'b0;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= BREAK;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        BREAK: begin
          // Hold off until the line recovers so a stuck-low line yields a
          // single framing error rather than a stream of bogus frames.
          tick <= '0;
          if (rx_sync) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          tick    <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int OS  = 16;
  localparam int DW  = 8;
  // Edge of the done/error register update, counting edge 1 as the first
  // edge that captures the falling start edge.
  localparam int LAT = 3 + OS / 2 + OS * (DW + 1);

  logic          BCLK = 1'b0;
  logic          reset;
  logic          rx;
  logic [DW-1:0] rx_dout;
  logic          rx_done_tk;
  logic          rx_frame_err;
  logic          rx_busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int         done_cyc_q[$];
  logic [7:0] done_val_q[$];
  int         err_cyc_q[$];
  int         bad_both = 0;
  int         bad_long = 0;
  logic       prev_done = 1'b0;
  logic       prev_err  = 1'b0;

  uart_rx #(.OVERSAMPLE(OS), .DATA_WIDTH(DW)) dut (
    .BCLK        (BCLK),
    .reset       (reset),
    .rx          (rx),
    .rx_dout     (rx_dout),
    .rx_done_tk  (rx_done_tk),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 BCLK = ~BCLK;

  always @(posedge BCLK) cyc <= cyc + 1;

  // Event recorder: logs every pulse with its cycle and flags pulses that
  // overlap or last longer than one cycle.
  always @(negedge BCLK) begin
    if (rx_done_tk === 1'b1) begin
      done_cyc_q.push_back(cyc);
      done_val_q.push_back(rx_dout);
    end
    if (rx_frame_err === 1'b1) err_cyc_q.push_back(cyc);
    if (rx_done_tk === 1'b1 && rx_frame_err === 1'b1) bad_both++;
    if ((rx_done_tk === 1'b1 && prev_done === 1'b1) ||
        (rx_frame_err === 1'b1 && prev_err === 1'b1)) bad_long++;
    prev_done = rx_done_tk;
    prev_err  = rx_frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] done_val(input int i);
    if (i < done_val_q.size()) return {24'd0, done_val_q[i]};
    return 'x;
  endfunction

  function automatic int done_at(input int i);
    if (i < done_cyc_q.size()) return done_cyc_q[i];
    return -1;
  endfunction

  function automatic int err_at(input int i);
    if (i < err_cyc_q.size()) return err_cyc_q[i];
    return -1;
  endfunction

  task automatic clear_log();
    done_cyc_q.delete();
    done_val_q.delete();
    err_cyc_q.delete();
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge BCLK);
  endtask

  // Behavioural transmitter: start bit, data LSB first, one stop bit.
  // Called on a falling edge; returns on a falling edge with the stop level
  // still on the line. start reports the cycle at which the start bit began.
  task automatic send(input logic [7:0] b, input logic stop, output int start);
    start = cyc;
    rx = 1'b0;
    repeat (OS) @(negedge BCLK);
    for (int i = 0; i < DW; i++) begin
      rx = b[i];
      repeat (OS) @(negedge BCLK);
    end
    rx = stop;
    repeat (OS) @(negedge BCLK);
  endtask

  task automatic wait_not_busy(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (rx_busy === 1'b0) break;
      @(negedge BCLK);
    end
  endtask

  initial begin
    int         s0;
    int         s1;
    logic [7:0] b;
    int         gap;
    int         exp_cyc[$];
    logic [7:0] exp_val[$];

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge BCLK);
    check("rst_dout", rx_dout, 0);
    check("rst_done", rx_done_tk, 0);
    check("rst_err", rx_frame_err, 0);
    check("rst_busy", rx_busy, 0);
    reset = 1'b0;
    idle(5);

    // Single good frame.
    clear_log();
    send(8'hA5, 1'b1, s0);
    idle(6);
    check("a5_count", done_cyc_q.size(), 1);
    check("a5_val", done_val(0), 8'hA5);
    check("a5_cycle", done_at(0), s0 + LAT);
    check("a5_err", err_cyc_q.size(), 0);
    check("a5_dout", rx_dout, 8'hA5);

    // Short low glitch.
    clear_log();
    rx = 1'b0;
    repeat (4) @(negedge BCLK);
    rx = 1'b1;
    check("glitch_busy_hi", rx_busy, 1);
    wait_not_busy(12);
    check("glitch_busy_lo", rx_busy, 0);
    idle(20);
    check("glitch_done", done_cyc_q.size(), 0);
    check("glitch_err", err_cyc_q.size(), 0);
    check("glitch_dout", rx_dout, 8'hA5);

    // Bad stop bit followed by a held-low line.
    clear_log();
    send(8'h3C, 1'b0, s0);
    repeat (40) @(negedge BCLK);
    check("brk_busy", rx_busy, 1);
    check("brk_err_count", err_cyc_q.size(), 1);
    check("brk_err_cycle", err_at(0), s0 + LAT);
    check("brk_done", done_cyc_q.size(), 0);
    rx = 1'b1;
    wait_not_busy(8);
    check("brk_release", rx_busy, 0);
    idle(20);
    check("brk_err_final", err_cyc_q.size(), 1);
    check("brk_dout", rx_dout, 8'hA5);

    // Back-to-back frames, no idle between stop and next start.
    clear_log();
    send(8'h00, 1'b1, s0);
    send(8'hFF, 1'b1, s1);
    idle(8);
    check("b2b_count", done_cyc_q.size(), 2);
    check("b2b_val0", done_val(0), 8'h00);
    check("b2b_val1", done_val(1), 8'hFF);
    check("b2b_cycle0", done_at(0), s0 + LAT);
    check("b2b_spacing", done_at(1) - done_at(0), OS * (DW + 2));
    check("b2b_err", err_cyc_q.size(), 0);

    // Reset in the middle of bit 4 of 0x81.
    clear_log();
    b  = 8'h81;
    rx = 1'b0;
    repeat (OS) @(negedge BCLK);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (OS) @(negedge BCLK);
    end
    rx = b[4];
    repeat (OS / 2) @(negedge BCLK);
    reset = 1'b1;
    rx    = 1'b1;
    #1;
    check("mid_rst_busy", rx_busy, 0);
    check("mid_rst_dout", rx_dout, 0);
    repeat (3) @(negedge BCLK);
    reset = 1'b0;
    idle(20);
    check("mid_rst_done", done_cyc_q.size(), 0);
    check("mid_rst_err", err_cyc_q.size(), 0);
    send(8'h5A, 1'b1, s0);
    idle(6);
    check("after_rst_count", done_cyc_q.size(), 1);
    check("after_rst_val", done_val(0), 8'h5A);
    check("after_rst_cycle", done_at(0), s0 + LAT);
    check("after_rst_dout", rx_dout, 8'h5A);

    // Random loopback with idle gaps of 0..20 cycles.
    clear_log();
    for (int k = 0; k < 256; k++) begin
      b   = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 20);
      send(b, 1'b1, s0);
      exp_val.push_back(b);
      exp_cyc.push_back(s0 + LAT);
      idle(gap);
    end
    idle(8);
    check("rand_count", done_cyc_q.size(), 256);
    check("rand_err", err_cyc_q.size(), 0);
    for (int k = 0; k < 256; k++) begin
      check($sformatf("rand_val[%0d]", k), done_val(k), {24'd0, exp_val[k]});
      check($sformatf("rand_cycle[%0d]", k), done_at(k), exp_cyc[k]);
    end

    check("pulse_overlap", bad_both, 0);
    check("pulse_width", bad_long, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
